trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap responder on the CPU side of the interrupt controller. It consumes `interrupt_req`/`interrupt_cause` and synchronous exceptions at the writeback (WB) stage. It owns the trap CSRs: mstatus, mie, mtvec, mscratch, mepc and mcause. It drives `global_int_enable` and `mie` back to the interrupt controller, and redirects the pipeline on trap entry and on `mret`.

## Interface
- No parameters.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `interrupt_req` input 1: prioritized interrupt request.
- `interrupt_cause` input 32: cause code for the request, e.g. 0x8000000B.
- `mip` input 32: pending register; readable only.
- `wb_valid` input 1: an instruction is retiring this cycle.
- `wb_pc` input 32: PC of the retiring instruction.
- `wb_next_pc` input 32: architectural next PC of the retiring instruction.
- `exc_valid` input 1: the retiring instruction raised an exception; qualified by `wb_valid`.
- `exc_cause` input 32: exception code (2 illegal, 3 ebreak, 11 ecall).
- `wb_mret` input 1: the retiring instruction is `mret`.
- `csr_we` input 1: CSR write from the retiring instruction.
- `csr_addr` input 12: CSR address.
- `csr_wdata` input 32: CSR write data.
- `csr_rdata` output 32: combinational read of `csr_addr`.
- `mie` output 32: interrupt-enable register.
- `mstatus` output 32: status register.
- `global_int_enable` output 1: equals mstatus[3].
- `int_ack` output 1: 1-cycle pulse in the cycle an interrupt is accepted.
- `trap_flush` output 1: registered 1-cycle pipeline flush.
- `trap_pc` output 32: redirect target; valid while `trap_flush`=1.

## Operation
- CSR map:
  - 0x300 mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - 0x304 mie: only bits 3, 7 and 11 are writable.
  - 0x305 mtvec: BASE[31:2] writable; MODE bit1 reads 0; MODE bit0 see Configuration.
  - 0x340 mscratch: fully writable.
  - 0x341 mepc: bits[1:0] read 0.
  - 0x342 mcause: fully writable.
  - 0x344 mip: reads the `mip` input; writes ignored.
  - Any other address reads 0; writes to it are ignored.
- An accepted CSR write requires `wb_valid & csr_we & ~exc_valid` in state RUN.
- Event priority in a RUN cycle with `wb_valid`=1:
  1. Exception: mepc←`wb_pc`, mcause←`exc_cause`; the CSR write is suppressed.
  2. mret: mstatus.MIE←MPIE, MPIE←1, `trap_pc`←mepc. No interrupt is taken in this cycle.
  3. Interrupt, when `interrupt_req`=1: mepc←`wb_next_pc`, mcause←`interrupt_cause`, `int_ack`=1. The instruction's CSR write still commits, but trap hardware updates override it on mepc, mcause and mstatus.
- Trap entry (exception or interrupt): MPIE←MIE, MIE←0; target per the mtvec rules in Configuration.
- Interrupts are accepted only at a retirement boundary (`wb_valid`=1).
- Pending-but-disabled requests are ignored; enable gating is done upstream.
- FSM:
  - RUN → TRAP on an accepted exception or interrupt.
  - RUN → RET on an accepted mret.
  - TRAP → RUN and RET → RUN unconditionally after one cycle.
  - In TRAP/RET, all `wb_*`, `exc_*`, `csr_we` and `interrupt_req` inputs are ignored, because the flushed instructions must not commit.

## Timing
- Event accepted in cycle N:
  - CSR updates are visible at the N→N+1 edge.
  - `trap_flush`=1 with `trap_pc` valid during N+1 only.
  - `int_ack` is combinational in cycle N.
- `csr_rdata` reflects register state with zero latency; there is no write-to-read bypass within the same cycle.
- `global_int_enable` falls in cycle N+1 after trap entry.
- On an accepted mret, `global_int_enable` takes its new value (old MPIE) in N+1. A pending interrupt can be taken at the next retirement in RUN, no earlier than N+2.
- Reset values (when `reset`=0):
  - mstatus=0x00001800; mie, mtvec, mscratch, mepc, mcause = 0.
  - FSM=RUN; `trap_flush`=0, `trap_pc`=0, `int_ack`=0.
- Reset asserted mid-TRAP aborts the flush; outputs take reset values immediately.

## Configuration
- `TRAP_VECTORED_EN` defined:
  - mtvec[0] is writable.
  - If MODE=1 and the trap is an interrupt, target = BASE + 4·cause[30:0].
  - Exceptions always target BASE.
- `TRAP_VECTORED_EN` not defined:
  - mtvec[0] is hardwired to 0 and all traps target {BASE, 2'b00}.

## Test plan
- **Reset:** assert `reset`=0 mid-run → mstatus reads 0x1800, mepc=0, `trap_flush`=0.
- **Interrupt entry:**
  - Stimulus: mtvec=0x100, mstatus.MIE=1, `interrupt_req`=1, cause 0x8000000B, `wb_valid`=1, `wb_next_pc`=0x2004.
  - Response: `int_ack`=1; next cycle `trap_flush`=1, `trap_pc`=0x100, mepc=0x2004, mcause=0x8000000B, mstatus=0x1880.
- **Exception over interrupt:**
  - Stimulus: `exc_valid`=1 (cause 2) and `interrupt_req`=1 at `wb_pc`=0x3000, `csr_we` to mscratch.
  - Response: mepc=0x3000, mcause=2, mscratch unchanged, `int_ack`=0.
- **mret:**
  - Stimulus: mepc=0x2004, MPIE=1, MIE=0, `wb_mret`=1 with `interrupt_req`=1.
  - Response: no `int_ack` that cycle; next cycle `trap_pc`=0x2004, mstatus=0x1888; interrupt taken at the next retirement.
- **Flush shadow:** `wb_valid`/`csr_we` to mscratch during TRAP → ignored, mscratch unchanged.
- **Vectored mode (`TRAP_VECTORED_EN` defined):**
  - Stimulus: mtvec=0x101, timer interrupt cause 0x80000007.
  - Response: `trap_pc`=0x11C; without the macro, mtvec reads 0x100 and `trap_pc`=0x100.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap responder: owns mstatus/mie/mtvec/mscratch/mepc/mcause and
// redirects the pipeline on trap entry and mret. Optional macro: TRAP_VECTORED_EN.
module trap_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt_req,
    input  logic [31:0] interrupt_cause,
    input  logic [31:0] mip,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_next_pc,
    input  logic        exc_valid,
    input  logic [31:0] exc_cause,
    input  logic        wb_mret,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic [31:0] mie,
    output logic [31:0] mstatus,
    output logic        global_int_enable,
    output logic        int_ack,
    output logic        trap_flush,
    output logic [31:0] trap_pc
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;

    typedef enum logic [1:0] {RUN, TRAP, RET} state_t;

    typedef struct packed {
        logic exc;
        logic ret;
        logic irq;
        logic wr;
    } evt_t;

    state_t      state_q, state_d;
    evt_t        evt;
    logic        st_mie, st_mpie;
    logic [31:0] mie_q;
    logic [29:0] mtvec_base;
    logic        mtvec_mode;
    logic [31:0] mscratch_q;
    logic [29:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] vec_pc;
    logic        retire;
    logic        unused_bits;

    assign unused_bits = ^{wb_pc[1:0], wb_next_pc[1:0], interrupt_cause[31:30]};

    // Flushed instructions in TRAP/RET never reach this decode.
    assign retire   = (state_q == RUN) & wb_valid;
    assign evt.exc  = retire & exc_valid;
    assign evt.ret  = retire & ~exc_valid & wb_mret;
    assign evt.irq  = retire & ~exc_valid & ~wb_mret & interrupt_req;
    assign evt.wr   = retire & ~exc_valid & csr_we;

    assign int_ack           = evt.irq & reset;
    assign mstatus           = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign mie               = mie_q;
    assign global_int_enable = st_mie;

`ifdef TRAP_VECTORED_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mtvec_mode <= 1'b0;
        else if (evt.wr && csr_addr == A_MTVEC)
            mtvec_mode <= csr_wdata[0];
    end

    // Only interrupts are vectored; exceptions share BASE.
    always_comb begin
        vec_pc = {mtvec_base, 2'b00};
        if (mtvec_mode && evt.irq)
            vec_pc = {mtvec_base, 2'b00} + {interrupt_cause[29:0], 2'b00};
    end
`else
    assign mtvec_mode = 1'b0;
    assign vec_pc     = {mtvec_base, 2'b00};
`endif

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            A_MSTATUS:  csr_rdata = mstatus;
            A_MIE:      csr_rdata = mie_q;
            A_MTVEC:    csr_rdata = {mtvec_base, 1'b0, mtvec_mode};
            A_MSCRATCH: csr_rdata = mscratch_q;
            A_MEPC:     csr_rdata = {mepc_q, 2'b00};
            A_MCAUSE:   csr_rdata = mcause_q;
            A_MIP:      csr_rdata = mip;
            default:    csr_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (evt.exc || evt.irq)
                    state_d = TRAP;
                else if (evt.ret)
                    state_d = RET;
            end
            TRAP:    state_d = RUN;
            RET:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Trap hardware takes precedence over a same-cycle software write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
        end else if (evt.exc || evt.irq) begin
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (evt.ret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (evt.wr && csr_addr == A_MSTATUS) begin
            st_mie  <= csr_wdata[3];
            st_mpie <= csr_wdata[7];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mie_q      <= 32'h0;
            mtvec_base <= 30'h0;
            mscratch_q <= 32'h0;
        end else if (evt.wr) begin
            if (csr_addr == A_MIE)      mie_q      <= csr_wdata & MIE_MASK;
            if (csr_addr == A_MTVEC)    mtvec_base <= csr_wdata[31:2];
            if (csr_addr == A_MSCRATCH) mscratch_q <= csr_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mepc_q   <= 30'h0;
            mcause_q <= 32'h0;
        end else if (evt.exc) begin
            mepc_q   <= wb_pc[31:2];
            mcause_q <= exc_cause;
        end else if (evt.irq) begin
            mepc_q   <= wb_next_pc[31:2];
            mcause_q <= interrupt_cause;
        end else if (evt.wr) begin
            if (csr_addr == A_MEPC)   mepc_q   <= csr_wdata[31:2];
            if (csr_addr == A_MCAUSE) mcause_q <= csr_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trap_flush <= 1'b0;
            trap_pc    <= 32'h0;
        end else begin
            trap_flush <= evt.exc | evt.irq | evt.ret;
            if (evt.exc || evt.irq)
                trap_pc <= vec_pc;
            else if (evt.ret)
                trap_pc <= {mepc_q, 2'b00};
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: CSR table, directed trap/mret sequences,
// and randomized retirement traffic against an architectural model.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        interrupt_req = 1'b0;
    logic [31:0] interrupt_cause = '0;
    logic [31:0] mip = '0;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [31:0] wb_next_pc = '0;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_cause = '0;
    logic        wb_mret = 1'b0;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata, mie, mstatus, trap_pc;
    logic        global_int_enable, int_ack, trap_flush;

    trap_ctrl dut (
        .clk(clk), .reset(reset), .interrupt_req(interrupt_req),
        .interrupt_cause(interrupt_cause), .mip(mip), .wb_valid(wb_valid),
        .wb_pc(wb_pc), .wb_next_pc(wb_next_pc), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .wb_mret(wb_mret), .csr_we(csr_we),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .mie(mie), .mstatus(mstatus), .global_int_enable(global_int_enable),
        .int_ack(int_ack), .trap_flush(trap_flush), .trap_pc(trap_pc)
    );

    always #5 clk = ~clk;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] MTV_MASK = 32'hFFFF_FFFD;
`else
    localparam logic [31:0] MTV_MASK = 32'hFFFF_FFFC;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model: plain register values plus "next cycle is a flush shadow".
    bit          m_mie, m_mpie, m_shadow, m_flush;
    logic [31:0] m_mier, m_mtvec, m_mscratch, m_mepc, m_mcause, m_tpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_mstatus();
        return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus();
            12'h304: return m_mier;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return mip;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_ack();
        return !m_shadow && wb_valid && !exc_valid && !wb_mret && interrupt_req;
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_shadow = 0; m_flush = 0;
        m_mier = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_tpc = 0;
    endtask

    task automatic model_step();
        bit          o_mie, o_mpie;
        logic [31:0] o_mtvec, o_mepc, base;
        o_mie = m_mie; o_mpie = m_mpie; o_mtvec = m_mtvec; o_mepc = m_mepc;
        base = o_mtvec & 32'hFFFF_FFFC;
        if (m_shadow || !wb_valid) begin
            m_shadow = 0; m_flush = 0;
            return;
        end
        if (!exc_valid && csr_we) begin
            case (csr_addr)
                12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                12'h304: m_mier = csr_wdata & 32'h888;
                12'h305: m_mtvec = csr_wdata & MTV_MASK;
                12'h340: m_mscratch = csr_wdata;
                12'h341: m_mepc = csr_wdata & 32'hFFFF_FFFC;
                12'h342: m_mcause = csr_wdata;
                default: ;
            endcase
        end
        if (exc_valid) begin
            m_mepc = wb_pc & 32'hFFFF_FFFC; m_mcause = exc_cause;
            m_mpie = o_mie; m_mie = 0; m_tpc = base;
            m_flush = 1; m_shadow = 1;
        end else if (wb_mret) begin
            m_mie = o_mpie; m_mpie = 1; m_tpc = o_mepc;
            m_flush = 1; m_shadow = 1;
        end else if (interrupt_req) begin
            m_mepc = wb_next_pc & 32'hFFFF_FFFC; m_mcause = interrupt_cause;
            m_mpie = o_mie; m_mie = 0;
            m_tpc = o_mtvec[0] ? base + 32'(interrupt_cause[30:0]) * 4 : base;
            m_flush = 1; m_shadow = 1;
        end else begin
            m_flush = 0; m_shadow = 0;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        chk("int_ack", {31'b0, int_ack}, {31'b0, m_ack()});
        chk("csr_rdata", csr_rdata, m_read(csr_addr));
        chk("mstatus", mstatus, m_mstatus());
        chk("mie", mie, m_mier);
        chk("gie", {31'b0, global_int_enable}, {31'b0, m_mie});
        chk("trap_flush", {31'b0, trap_flush}, {31'b0, m_flush});
        if (m_flush) chk("trap_pc", trap_pc, m_tpc);
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wb_valid = 0; exc_valid = 0; wb_mret = 0; csr_we = 0; interrupt_req = 0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        idle(); wb_valid = 1; csr_we = 1; csr_addr = a; csr_wdata = d;
        tick();
        idle();
    endtask

    task automatic read_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a; #1;
        chk(name, csr_rdata, exp);
    endtask

    task automatic do_reset();
        idle(); reset = 0; model_reset();
        @(negedge clk); @(negedge clk);
        reset = 1;
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[9];
    logic [11:0] addrs[10];

    initial begin
        vt[0] = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888};
        vt[1] = '{12'h300, 32'h0000_0000, 32'h0000_1800};
        vt[2] = '{12'h304, 32'hFFFF_FFFF, 32'h0000_0888};
`ifdef TRAP_VECTORED_EN
        vt[3] = '{12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
`else
        vt[3] = '{12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
`endif
        vt[4] = '{12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[5] = '{12'h341, 32'h1234_5677, 32'h1234_5674};
        vt[6] = '{12'h342, 32'h8000_000B, 32'h8000_000B};
        vt[7] = '{12'h344, 32'hFFFF_FFFF, 32'h0000_0888};
        vt[8] = '{12'h7C0, 32'hFFFF_FFFF, 32'h0000_0000};
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                  12'h342, 12'h344, 12'h7C0, 12'h301, 12'h343};

        model_reset();
        @(negedge clk); @(negedge clk);
        #1;
        chk("reset_mstatus", mstatus, 32'h0000_1800);
        chk("reset_flush", {31'b0, trap_flush}, 32'h0);
        chk("reset_trap_pc", trap_pc, 32'h0);
        reset = 1;
        @(negedge clk);

        // CSR write/readback table
        mip = 32'h0000_0888;
        foreach (vt[i]) begin
            csr_write(vt[i].addr, vt[i].wdata);
            read_chk($sformatf("csr_tbl_%03h", vt[i].addr), vt[i].addr, vt[i].exp);
        end

        // Interrupt entry
        do_reset(); @(negedge clk);
        csr_write(12'h305, 32'h100);
        csr_write(12'h300, 32'h8);
        wb_valid = 1; interrupt_req = 1; interrupt_cause = 32'h8000_000B;
        wb_next_pc = 32'h2004; wb_pc = 32'h2000; #1;
        chk("irq_ack", {31'b0, int_ack}, 32'h1);
        tick(); idle(); #1;
        chk("irq_flush", {31'b0, trap_flush}, 32'h1);
        chk("irq_trap_pc", trap_pc, 32'h100);
        chk("irq_mstatus", mstatus, 32'h1880);
        chk("irq_gie", {31'b0, global_int_enable}, 32'h0);
        read_chk("irq_mepc", 12'h341, 32'h2004);
        read_chk("irq_mcause", 12'h342, 32'h8000_000B);
        tick();

        // mret with a pending interrupt
        wb_valid = 1; wb_mret = 1; interrupt_req = 1; #1;
        chk("mret_no_ack", {31'b0, int_ack}, 32'h0);
        tick();
        wb_mret = 0; wb_valid = 1; interrupt_req = 1; #1;
        chk("mret_trap_pc", trap_pc, 32'h2004);
        chk("mret_mstatus", mstatus, 32'h1888);
        chk("ret_shadow_ack", {31'b0, int_ack}, 32'h0);
        tick();
        #1;
        chk("post_mret_ack", {31'b0, int_ack}, 32'h1);
        tick(); idle(); tick();

        // Exception over interrupt, then flush shadow
        csr_write(12'h340, 32'h55);
        wb_valid = 1; exc_valid = 1; exc_cause = 2; wb_pc = 32'h3000;
        interrupt_req = 1; csr_we = 1; csr_addr = 12'h340; csr_wdata = 32'hAA; #1;
        chk("exc_no_ack", {31'b0, int_ack}, 32'h0);
        tick();
        exc_valid = 0; interrupt_req = 0; wb_valid = 1; csr_we = 1;
        csr_addr = 12'h340; csr_wdata = 32'h77;
        tick(); idle();
        read_chk("exc_mscratch", 12'h340, 32'h55);
        read_chk("exc_mepc", 12'h341, 32'h3000);
        read_chk("exc_mcause", 12'h342, 32'h2);

        // Vectored target
        csr_write(12'h305, 32'h101);
        csr_write(12'h300, 32'h8);
`ifdef TRAP_VECTORED_EN
        read_chk("vec_mtvec", 12'h305, 32'h101);
`else
        read_chk("vec_mtvec", 12'h305, 32'h100);
`endif
        wb_valid = 1; interrupt_req = 1; interrupt_cause = 32'h8000_0007;
        tick(); idle(); #1;
`ifdef TRAP_VECTORED_EN
        chk("vec_trap_pc", trap_pc, 32'h11C);
`else
        chk("vec_trap_pc", trap_pc, 32'h100);
`endif
        // Reset in the TRAP cycle aborts the flush
        reset = 0; model_reset(); #1;
        chk("rst_mid_flush", {31'b0, trap_flush}, 32'h0);
        chk("rst_mid_mstatus", mstatus, 32'h1800);
        read_chk("rst_mid_mepc", 12'h341, 32'h0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);

        // Randomized retirement traffic
        for (int c = 0; c < 600; c++) begin
            wb_valid        = ($urandom_range(0, 9) < 7);
            exc_valid       = ($urandom_range(0, 9) < 2);
            wb_mret         = ($urandom_range(0, 9) < 2);
            interrupt_req   = ($urandom_range(0, 9) < 3);
            csr_we          = ($urandom_range(0, 9) < 5);
            csr_addr        = addrs[$urandom_range(0, 9)];
            csr_wdata       = $urandom;
            wb_pc           = $urandom;
            wb_next_pc      = $urandom;
            exc_cause       = $urandom_range(0, 15);
            interrupt_cause = 32'h8000_0000 | $urandom_range(0, 15);
            mip             = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
